// File: rtl/traffic_pkg.sv
// traffic_pkg -- shared types and constants for the traffic phase controller.
//   phase_e    : controller phase, encoded to match the 2-bit phase output
//   LT_*       : 5-bit light codes {Red, Orange, LeftGreen, FrontGreen, RightGreen}
package traffic_pkg;

   typedef enum logic [1:0] {
      ALL_RED = 2'd0,
      GREEN   = 2'd1,
      AMBER   = 2'd2
   } phase_e;

   localparam logic [4:0] LT_RED   = 5'b10000;
   localparam logic [4:0] LT_FREE  = 5'b10100;
   localparam logic [4:0] LT_AMBER = 5'b01000;
   localparam logic [4:0] LT_GFULL = 5'b00111;
   localparam logic [4:0] LT_GPART = 5'b00110;

endpackage

// File: rtl/rr_pick.sv
// rr_pick -- round-robin first-set search.
// Starting at index 'start' and wrapping modulo N, returns the first index
// whose request bit is set.
//   req   in  N      request vector
//   start in  SEL_W  first index to examine (must be < N)
//   idx   out SEL_W  first requesting index found (0 when none)
//   valid out 1      at least one request bit is set
module rr_pick #(
   parameter int N     = 4,
   parameter int SEL_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] start,
   output logic [SEL_W-1:0] idx,
   output logic             valid
);

   // cand[gi] is the board examined gi places after 'start'. One extra bit
   // on the sum keeps the wrap test exact for non-power-of-two N.
   logic [SEL_W-1:0] cand [N];

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_cand
         logic [SEL_W:0] sum;
         assign sum = {1'b0, start} + (SEL_W+1)'(gi);
         assign cand[gi] = (sum >= (SEL_W+1)'(N)) ? SEL_W'(sum - (SEL_W+1)'(N))
                                                  : sum[SEL_W-1:0];
      end
   endgenerate

   // Scan from the far end so the smallest offset from 'start' wins.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[cand[i]]) begin
            idx   = cand[i];
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl -- N-approach traffic phase controller.
// Cycles GREEN -> AMBER -> ALL_RED round-robin over the boards, advancing only
// on tick. Emergency requests select first and can cut a green short once
// MIN_GREEN ticks have elapsed; load-priority requests are latched and steer
// the next selection but never preempt.
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   tick         in   timing strobe
//   p            in   load-priority requests (latched sticky)
//   e            in   emergency requests (level)
//   lights       out  5 bits per board, board k at [5k+4:5k]
//   active_board out  board owning the current or most recent green
//   phase        out  0=ALL_RED, 1=GREEN, 2=AMBER
//   countdown    out  ticks remaining in the phase minus 1
//   preempted    out  high through the AMBER/ALL_RED after a cut-short green
//   phase_start  out  one-clk pulse when a phase is entered
module traffic_phase_ctrl
   import traffic_pkg::*;
#(
   parameter int N_BOARDS     = 4,
   parameter int GREEN_TICKS  = 30,
   parameter int AMBER_TICKS  = 8,
   parameter int ALLRED_TICKS = 2,
   parameter int MIN_GREEN    = 10,
   parameter int FREE_LEFT    = 1,
   parameter int CNT_W        = 8,
   parameter int SEL_W        = $clog2(N_BOARDS)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    tick,
   input  logic [N_BOARDS-1:0]     p,
   input  logic [N_BOARDS-1:0]     e,
   output logic [5*N_BOARDS-1:0]   lights,
   output logic [SEL_W-1:0]        active_board,
   output logic [1:0]              phase,
   output logic [CNT_W-1:0]        countdown,
   output logic                    preempted,
   output logic                    phase_start
);

   localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_TICKS - 1);
   localparam logic [CNT_W-1:0] AMBER_LOAD  = CNT_W'(AMBER_TICKS - 1);
   localparam logic [CNT_W-1:0] ALLRED_LOAD = CNT_W'(ALLRED_TICKS - 1);
   localparam logic [CNT_W-1:0] GREEN_HALF  = CNT_W'(GREEN_TICKS / 2);
   // elapsed counts completed green ticks and saturates here; a preemption
   // tick is itself the MIN_GREEN-th green tick.
   localparam logic [CNT_W-1:0] MG_LAST     = CNT_W'(MIN_GREEN - 1);
   localparam logic [4:0]       IDLE_CODE   = (FREE_LEFT != 0) ? LT_FREE : LT_RED;

   phase_e                phase_reg, phase_next;
   logic [CNT_W-1:0]      cnt_reg, cnt_next;
   logic [CNT_W-1:0]      elapsed_reg, elapsed_next;
   logic [SEL_W-1:0]      active_reg, active_next;
   logic [N_BOARDS-1:0]   pending_reg, pending_next;
   logic                  preempted_reg, preempted_next;
   logic                  start_reg, start_next;
   logic [5*N_BOARDS-1:0] lights_reg, lights_next;

   logic [N_BOARDS-1:0]   active_mask, clear_mask;
   logic [SEL_W-1:0]      succ, e_idx, p_idx, sel;
   logic                  e_valid, p_valid, e_active, e_other;
   logic                  natural_end, preempt_now;
   logic [4:0]            board_code [N_BOARDS];

   // ---------------- next-board selection ----------------
   assign succ = (active_reg == SEL_W'(N_BOARDS - 1)) ? '0 : active_reg + SEL_W'(1);

   always_comb begin
      e_idx   = '0;
      e_valid = 1'b0;
      for (int i = N_BOARDS - 1; i >= 0; i--) begin
         if (e[i]) begin
            e_idx   = SEL_W'(i);
            e_valid = 1'b1;
         end
      end
   end

   rr_pick #(.N(N_BOARDS), .SEL_W(SEL_W)) u_pick (
      .req   (pending_reg),
      .start (succ),
      .idx   (p_idx),
      .valid (p_valid)
   );

   assign sel = e_valid ? e_idx : (p_valid ? p_idx : succ);

   assign active_mask = N_BOARDS'(1) << active_reg;
   assign e_active    = |(e & active_mask);
   assign e_other     = |(e & ~active_mask);
   assign natural_end = (cnt_reg == '0) && !e_active;
   assign preempt_now = e_other && (elapsed_reg >= MG_LAST);

   // ---------------- phase sequencing ----------------
   always_comb begin
      phase_next     = phase_reg;
      cnt_next       = cnt_reg;
      elapsed_next   = elapsed_reg;
      active_next    = active_reg;
      preempted_next = preempted_reg;
      start_next     = 1'b0;
      clear_mask     = '0;
      if (tick) begin
         case (phase_reg)
            ALL_RED: begin
               if (cnt_reg == '0) begin
                  phase_next     = GREEN;
                  cnt_next       = GREEN_LOAD;
                  elapsed_next   = '0;
                  active_next    = sel;
                  preempted_next = 1'b0;
                  start_next     = 1'b1;
                  clear_mask     = N_BOARDS'(1) << sel;
               end else begin
                  cnt_next = cnt_reg - CNT_W'(1);
               end
            end
            GREEN: begin
               if (natural_end || preempt_now) begin
                  phase_next     = AMBER;
                  cnt_next       = AMBER_LOAD;
                  preempted_next = preempt_now && !natural_end;
                  start_next     = 1'b1;
               end else begin
                  // At countdown 0 the green is held by its own emergency.
                  if (cnt_reg != '0)
                     cnt_next = cnt_reg - CNT_W'(1);
                  if (elapsed_reg < MG_LAST)
                     elapsed_next = elapsed_reg + CNT_W'(1);
               end
            end
            AMBER: begin
               if (cnt_reg == '0) begin
                  phase_next = ALL_RED;
                  cnt_next   = ALLRED_LOAD;
                  start_next = 1'b1;
               end else begin
                  cnt_next = cnt_reg - CNT_W'(1);
               end
            end
            default: begin
               phase_next = ALL_RED;
               cnt_next   = '0;
            end
         endcase
      end
   end

   // p is sampled every clock; the newly served board's clear beats a
   // same-cycle set only for that board.
   assign pending_next = (pending_reg | p) & ~clear_mask;

   // ---------------- light codes (from next state, so registered in step) ----
   genvar gi;
   generate
      for (gi = 0; gi < N_BOARDS; gi++) begin : g_light
         assign board_code[gi] =
            (phase_next == ALL_RED)          ? LT_RED    :
            (active_next != SEL_W'(gi))      ? IDLE_CODE :
            (phase_next == AMBER)            ? LT_AMBER  :
            (cnt_next >= GREEN_HALF)         ? LT_GFULL  : LT_GPART;
      end
   endgenerate

   always_comb begin
      lights_next = '0;
      for (int k = 0; k < N_BOARDS; k++)
         lights_next[5*k +: 5] = board_code[k];
   end

   // ---------------- state registers ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase_reg     <= ALL_RED;
         cnt_reg       <= '0;
         elapsed_reg   <= '0;
         active_reg    <= SEL_W'(N_BOARDS - 1);
         pending_reg   <= '0;
         preempted_reg <= 1'b0;
         start_reg     <= 1'b0;
         lights_reg    <= {N_BOARDS{LT_RED}};
      end else begin
         phase_reg     <= phase_next;
         cnt_reg       <= cnt_next;
         elapsed_reg   <= elapsed_next;
         active_reg    <= active_next;
         pending_reg   <= pending_next;
         preempted_reg <= preempted_next;
         start_reg     <= start_next;
         lights_reg    <= lights_next;
      end
   end

   assign lights       = lights_reg;
   assign active_board = active_reg;
   assign phase        = phase_reg;
   assign countdown    = cnt_reg;
   assign preempted    = preempted_reg;
   assign phase_start  = start_reg;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl -- directed bench for traffic_phase_ctrl with
// N=4, GREEN=6, AMBER=2, ALLRED=1, MIN_GREEN=2, FREE_LEFT=1.
// Expected values are hand-derived: green shows 00111 for countdown 5..3 and
// 00110 for 2..0, amber 01000 for countdown 1..0, all-red for one tick.
module tb_traffic_phase_ctrl;

   localparam logic [4:0]  LG = 5'b00111;
   localparam logic [4:0]  LP = 5'b00110;
   localparam logic [4:0]  LA = 5'b01000;
   localparam logic [19:0] ALLRED = 20'b10000_10000_10000_10000;

   logic        clk;
   logic        reset;
   logic        tick;
   logic [3:0]  p;
   logic [3:0]  e;
   logic [19:0] lights;
   logic [1:0]  active_board;
   logic [1:0]  phase;
   logic [7:0]  countdown;
   logic        preempted;
   logic        phase_start;

   int n_assert = 0;
   int n_fail   = 0;

   traffic_phase_ctrl #(
      .N_BOARDS(4), .GREEN_TICKS(6), .AMBER_TICKS(2), .ALLRED_TICKS(1),
      .MIN_GREEN(2), .FREE_LEFT(1), .CNT_W(8), .SEL_W(2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .tick         (tick),
      .p            (p),
      .e            (e),
      .lights       (lights),
      .active_board (active_board),
      .phase        (phase),
      .countdown    (countdown),
      .preempted    (preempted),
      .phase_start  (phase_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   // Board b shows 'code', every other board shows red + free left.
   function automatic logic [19:0] lts(input int b, input logic [4:0] code);
      logic [19:0] v;
      for (int k = 0; k < 4; k++)
         v[5*k +: 5] = (k == b) ? code : 5'b10100;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_st(input string tag, input int ph, input int act, input int cnt,
                         input logic [19:0] lt);
      $display("[%0t] %s phase=%0d board=%0d cnt=%0d lights=%b pre=%b ps=%b",
               $time, tag, phase, active_board, countdown, lights, preempted, phase_start);
      chk({tag, ".phase"},  32'(phase),        32'(ph));
      chk({tag, ".board"},  32'(active_board), 32'(act));
      chk({tag, ".cnt"},    32'(countdown),    32'(cnt));
      chk({tag, ".lights"}, 32'(lights),       32'(lt));
   endtask

   // Steps k = k0 .. k1-1 of an unpreempted 9-tick cycle of board b.
   // k=0 is the green-entry edge. pmask is driven on p for one clk after k=1.
   task automatic run_cycle(input int b, input logic [3:0] pmask, input int k0, input int k1);
      int ph, cnt;
      logic [19:0] lt;
      for (int k = k0; k < k1; k++) begin
         step();
         if (k < 3)      begin ph = 1; cnt = 5 - k; lt = lts(b, LG); end
         else if (k < 6) begin ph = 1; cnt = 5 - k; lt = lts(b, LP); end
         else if (k < 8) begin ph = 2; cnt = 7 - k; lt = lts(b, LA); end
         else            begin ph = 0; cnt = 0;     lt = ALLRED;     end
         chk_st($sformatf("b%0d.k%0d", b, k), ph, b, cnt, lt);
         chk($sformatf("b%0d.k%0d.ps", b, k), 32'(phase_start),
             32'((k == 0 || k == 6 || k == 8) ? 1 : 0));
         if (k == 1) p = pmask;
         if (k == 2) p = 4'b0000;
      end
   endtask

   initial begin
      reset = 1'b0;
      tick  = 1'b1;
      p     = 4'b0000;
      e     = 4'b0000;

      // ---- reset state ----
      step();
      step();
      chk_st("rst", 0, 3, 0, ALLRED);
      chk("rst.pre", 32'(preempted),   32'd0);
      chk("rst.ps",  32'(phase_start), 32'd0);

      // ---- idle rotation 0,1,2,3 then load priority on board 0 ----
      reset = 1'b1;
      run_cycle(0, 4'b0000, 0, 9);
      run_cycle(1, 4'b0000, 0, 9);
      run_cycle(2, 4'b0000, 0, 9);
      run_cycle(3, 4'b0000, 0, 9);
      run_cycle(0, 4'b1000, 0, 9);   // p[3] pulse; board 0 still runs full length
      run_cycle(3, 4'b0000, 0, 9);   // pending p[3] beats round-robin board 1
      chk("lp.pre", 32'(preempted), 32'd0);

      // ---- reset mid-AMBER of board 0 ----
      run_cycle(0, 4'b0000, 0, 7);
      reset = 1'b0;
      #1;
      chk_st("arst", 0, 3, 0, ALLRED);
      chk("arst.pre", 32'(preempted), 32'd0);
      step();
      step();
      reset = 1'b1;

      // ---- emergency preemption on board 0 by e[2] ----
      step();
      chk_st("pre.e0", 1, 0, 5, lts(0, LG));
      e = 4'b0100;
      step();
      chk_st("pre.e1", 1, 0, 4, lts(0, LG));
      chk("pre.e1.pre", 32'(preempted), 32'd0);
      step();
      chk_st("pre.e2", 2, 0, 1, lts(0, LA));
      chk("pre.e2.pre", 32'(preempted),   32'd1);
      chk("pre.e2.ps",  32'(phase_start), 32'd1);
      step();
      chk_st("pre.e3", 2, 0, 0, lts(0, LA));
      step();
      chk_st("pre.e4", 0, 0, 0, ALLRED);
      chk("pre.e4.pre", 32'(preempted), 32'd1);
      step();
      chk_st("pre.e5", 1, 2, 5, lts(2, LG));
      chk("pre.e5.pre", 32'(preempted), 32'd0);
      e = 4'b0000;
      run_cycle(2, 4'b0000, 1, 8);

      // ---- emergency selection and hold on board 1 ----
      e = 4'b0010;
      run_cycle(2, 4'b0000, 8, 9);
      run_cycle(1, 4'b0000, 0, 6);   // e[1] wins over round-robin board 3
      for (int h = 0; h < 4; h++) begin
         step();
         chk_st($sformatf("hold%0d", h), 1, 1, 0, lts(1, LP));
      end
      e = 4'b0000;
      step();
      chk_st("hold.amb", 2, 1, 1, lts(1, LA));
      chk("hold.pre", 32'(preempted), 32'd0);
      step();
      chk_st("hold.amb2", 2, 1, 0, lts(1, LA));
      step();
      chk_st("hold.ar", 0, 1, 0, ALLRED);

      // ---- tick gating mid-GREEN on board 2 ----
      run_cycle(2, 4'b0000, 0, 3);
      tick = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (i == 0 || i == 19) begin
            chk_st($sformatf("gate%0d", i), 1, 2, 3, lts(2, LG));
            chk($sformatf("gate%0d.ps", i), 32'(phase_start), 32'd0);
         end
      end
      tick = 1'b1;
      run_cycle(2, 4'b0000, 3, 8);

      // ---- simultaneous emergencies: lowest index wins ----
      e = 4'b1010;
      run_cycle(2, 4'b0000, 8, 9);
      step();
      chk_st("multi.e", 1, 1, 5, lts(1, LG));
      e = 4'b0000;
      run_cycle(1, 4'b0000, 1, 4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
